// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first repeat_cnt times, with gap_len zero bits between frames.
// Optional macro PARITY_BIT_EN appends an even-parity bit to every frame.
module seq_pattern_gen #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] gap_len,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

`ifdef PARITY_BIT_EN
  localparam int                 FRAME_W = PAT_W + 1;
  localparam logic [FRAME_W-1:0] FRAME   = {PATTERN, ^PATTERN};
`else
  localparam int                 FRAME_W = PAT_W;
  localparam logic [FRAME_W-1:0] FRAME   = PATTERN;
`endif

  localparam int               IDX_W   = $clog2(FRAME_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(FRAME_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] rem_cnt;
  logic [CNT_W-1:0] gap_reg;
  logic [CNT_W-1:0] gap_ctr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      rem_cnt     <= '0;
      gap_reg     <= '0;
      gap_ctr     <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            frames_sent <= '0;
            if (repeat_cnt != '0) begin
              rem_cnt <= repeat_cnt;
              gap_reg <= gap_len;
              bit_idx <= IDX_TOP;
              state   <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          // Abort wins even on the last bit: a frame only counts once the state machine moves past it.
          if (abort) begin
            state <= IDLE;
          end else if (bit_idx == '0) begin
            frames_sent <= frames_sent + CNT_W'(1);
            rem_cnt     <= rem_cnt - CNT_W'(1);
            if (rem_cnt == CNT_W'(1)) begin
              state <= DONE;
            end else if (gap_reg == '0) begin
              bit_idx <= IDX_TOP;
            end else begin
              gap_ctr <= gap_reg;
              state   <= GAP;
            end
          end else begin
            bit_idx <= bit_idx - IDX_W'(1);
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
          end else if (gap_ctr == CNT_W'(1)) begin
            bit_idx <= IDX_TOP;
            state   <= SHIFT;
          end else begin
            gap_ctr <= gap_ctr - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == SHIFT) || (state == GAP);
  assign dout_valid = busy;
  assign dout       = (state == SHIFT) && FRAME[bit_idx];
  assign done       = (state == DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: table of transfers checked through an expected-bit queue, plus reset/abort/boundary sequences.
module tb_seq_pattern_gen;

  localparam int CNT_W = 8;
`ifdef PARITY_BIT_EN
  localparam int FW = 5;
`else
  localparam int FW = 4;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] repeat_cnt;
  logic [CNT_W-1:0] gap_len;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] frames_sent;

  seq_pattern_gen #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rep;
    int          gap;
    int          abort_at;   // valid cycle during which abort is held (0 = none)
    int          start_mid;  // cycle in which a stray start is pulsed (0 = none)
    int          len;        // expected number of valid bits
    logic [31:0] stream;     // expected valid bits, first bit at position len-1
    int          frames;
    int          done_cyc;   // cycle after acceptance showing done (-1 = never)
    int          det;        // overlapping 1001 detections in the valid stream
  } vec_t;

  vec_t vecs[7];
  logic exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_dout"}, 32'(dout), 0);
    chk({name, "_valid"}, 32'(dout_valid), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int       vcount = 0;
    int       done_cyc = -1;
    int       dets = 0;
    logic [3:0] sh = '0;
    bit       fin = 1'b0;
    logic     e;
    for (int i = v.len - 1; i >= 0; i--) exp_q.push_back(v.stream[i]);
    @(negedge clk);
    repeat_cnt = CNT_W'(v.rep);
    gap_len    = CNT_W'(v.gap);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    repeat_cnt = 8'd7;
    gap_len    = 8'd5;
    for (int c = 1; c <= 400 && !fin; c++) begin
      if (c > 1) @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      if (busy !== dout_valid) chk({name, "_busy_eq_valid"}, 32'(busy), 32'(dout_valid));
      if (dout_valid === 1'b1) begin
        vcount++;
        if (exp_q.size() == 0) begin
          chk({name, "_extra_bit"}, 32'(vcount), 32'(v.len));
        end else begin
          e = exp_q.pop_front();
          chk({name, "_dout"}, 32'(dout), 32'(e));
        end
        sh = {sh[2:0], dout};
        if (vcount >= 4 && sh == 4'b1001) dets++;
      end
      if (done === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        chk({name, "_done_valid"}, 32'(dout_valid), 0);
      end
      if (c == v.abort_at) abort = 1'b1;
      if (c == v.start_mid) begin
        start      = 1'b1;
        repeat_cnt = 8'd9;
      end
      fin = (done_cyc >= 0) || (v.abort_at > 0 && c > v.abort_at && dout_valid === 1'b0);
    end
    chk({name, "_left_in_queue"}, 32'(exp_q.size()), 0);
    chk({name, "_valid_count"}, 32'(vcount), 32'(v.len));
    chk({name, "_done_cycle"}, 32'(done_cyc), 32'(v.done_cyc));
    chk({name, "_frames"}, 32'(frames_sent), 32'(v.frames));
    chk({name, "_detections"}, 32'(dets), 32'(v.det));
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk_idle({name, "_after"});
    end
    chk({name, "_frames_hold"}, 32'(frames_sent), 32'(v.frames));
  endtask

  initial begin
    int cnt;
    bit seen;
`ifdef PARITY_BIT_EN
    vecs[0] = '{1, 0, 0, 0,  5, 32'b10010,           1,  6, 1};
    vecs[1] = '{3, 0, 0, 0, 15, 32'b100101001010010, 3, 16, 3};
    vecs[2] = '{2, 2, 0, 0, 12, 32'b100100010010,    2, 13, 2};
    vecs[3] = '{0, 3, 0, 0,  0, 32'b0,               0,  1, 0};
    vecs[4] = '{3, 0, 7, 3,  7, 32'b1001010,         1, -1, 1};
    vecs[5] = '{2, 1, 0, 0, 11, 32'b10010010010,     2, 12, 3};
    vecs[6] = '{3, 2, 6, 0,  6, 32'b100100,          1, -1, 1};
`else
    vecs[0] = '{1, 0, 0, 0,  4, 32'b1001,            1,  5, 1};
    vecs[1] = '{3, 0, 0, 0, 12, 32'b100110011001,    3, 13, 3};
    vecs[2] = '{2, 2, 0, 0, 10, 32'b1001001001,      2, 11, 3};
    vecs[3] = '{0, 3, 0, 0,  0, 32'b0,               0,  1, 0};
    vecs[4] = '{3, 0, 6, 3,  6, 32'b100110,          1, -1, 1};
    vecs[5] = '{2, 1, 0, 0,  9, 32'b100101001,       2, 10, 2};
    vecs[6] = '{3, 2, 5, 0,  5, 32'b10010,           1, -1, 1};
`endif
    reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_cnt = '0; gap_len = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_frames", 32'(frames_sent), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start and abort together in IDLE: start must win
    @(negedge clk);
    repeat_cnt = 8'd1; gap_len = 8'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_beats_abort_busy", 32'(busy), 1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    chk("start_beats_abort_done", 32'(seen), 1);
    chk("start_beats_abort_frames", 32'(frames_sent), 1);

    // reset in the middle of a gap
    @(negedge clk);
    repeat_cnt = 8'd2; gap_len = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midgap_frames_before", 32'(frames_sent), 1);
    chk("midgap_in_gap_dout", 32'(dout), 0);
    chk("midgap_in_gap_valid", 32'(dout_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("midgap_reset");
    chk("midgap_reset_frames", 32'(frames_sent), 0);
    run_vec(vecs[0], "after_reset");

    // largest repeat count
    @(negedge clk);
    repeat_cnt = 8'd255; gap_len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (dout_valid === 1'b1) cnt++;
      seen = (done === 1'b1);
      if (!seen) @(negedge clk);
    end
    chk("max_rep_done", 32'(seen), 1);
    chk("max_rep_valid_count", 32'(cnt), 32'(255 * FW));
    chk("max_rep_frames", 32'(frames_sent), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
